goofy_alu: RTL and testbench

Two-register 8-bit arithmetic/logic unit for the Goofy CPU core. Holds operand registers R0/R1, executes one-cycle operations selected by one-hot strobes from the microcode word, and keeps overflow, equal and halt flags. The halt flag drives the core's `hlt` output. All state updates on the rising edge of `clk`.

---
 rtl/goofy_alu.sv | 128 ++++++++++++
 tb/tb_goofy_alu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/goofy_alu.sv
// Two-register 8-bit ALU with overflow/equal/halt flags for the Goofy CPU core.
// Latency: one cycle; every result and flag is registered on the rising edge of clk.
// Backpressure: none; a new operation may be strobed every cycle.
//
// Ports:
//   clk, res (synchronous, active-low; wins over every other input)
//   r0w/r0d/r0o, r1w/r1d/r1o : operand register load strobe, data and value
//   op_* strobes (expected one-hot; priority hlt > cmp > add > add_ov > sub >
//   sub_ov > and > or > not), flag_res clears ov/eq
//   out, flag_ov_o, flag_eq_o, flag_hlt_o : registered result and flags
//
// Build option: define GOOFY_ALU_CARRY_EN so that op_add_ov/op_sub_ov use ov as
// carry/borrow-in. Without it, those strobes behave exactly like op_add/op_sub.
module goofy_alu (
  input  logic       clk,
  input  logic       res,
  input  logic       r0w,
  output logic [7:0] r0o,
  input  logic [7:0] r0d,
  input  logic       r1w,
  output logic [7:0] r1o,
  input  logic [7:0] r1d,
  output logic       flag_ov_o,
  output logic       flag_eq_o,
  output logic       flag_hlt_o,
  output logic [7:0] out,
  input  logic       op_add,
  input  logic       op_add_ov,
  input  logic       op_sub,
  input  logic       op_sub_ov,
  input  logic       op_and,
  input  logic       op_or,
  input  logic       op_not,
  input  logic       op_cmp,
  input  logic       op_hlt,
  input  logic       flag_res
);

  logic [7:0] r0_q, r1_q, out_q;
  logic       ov_q, eq_q, hlt_q;

  // Priority-resolved strobes: exactly one of these is high at most.
  logic sel_hlt, sel_cmp, sel_add, sel_add_ov, sel_sub, sel_sub_ov;
  logic sel_and, sel_or, sel_not;

  always_comb begin
    sel_hlt    = 1'b0;
    sel_cmp    = 1'b0;
    sel_add    = 1'b0;
    sel_add_ov = 1'b0;
    sel_sub    = 1'b0;
    sel_sub_ov = 1'b0;
    sel_and    = 1'b0;
    sel_or     = 1'b0;
    sel_not    = 1'b0;
    if (op_hlt)         sel_hlt    = 1'b1;
    else if (op_cmp)    sel_cmp    = 1'b1;
    else if (op_add)    sel_add    = 1'b1;
    else if (op_add_ov) sel_add_ov = 1'b1;
    else if (op_sub)    sel_sub    = 1'b1;
    else if (op_sub_ov) sel_sub_ov = 1'b1;
    else if (op_and)    sel_and    = 1'b1;
    else if (op_or)     sel_or     = 1'b1;
    else if (op_not)    sel_not    = 1'b1;
  end

  // Carry/borrow source. flag_res takes effect before the op, so a same-cycle
  // flag_res also clears the carry-in seen by op_add_ov/op_sub_ov.
  logic carry_src;
`ifdef GOOFY_ALU_CARRY_EN
  assign carry_src = ov_q & ~flag_res;
`else
  assign carry_src = 1'b0;
`endif

  logic       cin;
  logic [8:0] sum, diff;

  assign cin  = (sel_add_ov | sel_sub_ov) & carry_src;
  assign sum  = {1'b0, r0_q} + {1'b0, r1_q} + {8'd0, cin};
  // Bit 8 of the 9-bit wrapped difference is the borrow out.
  assign diff = {1'b0, r0_q} - {1'b0, r1_q} - {8'd0, cin};

  always_ff @(posedge clk) begin
    if (!res) begin
      r0_q  <= 8'h00;
      r1_q  <= 8'h00;
      out_q <= 8'h00;
      ov_q  <= 1'b0;
      eq_q  <= 1'b0;
      hlt_q <= 1'b0;
    end else if (!hlt_q) begin
      if (r0w) r0_q <= r0d;
      if (r1w) r1_q <= r1d;
      if (flag_res) begin
        ov_q <= 1'b0;
        eq_q <= 1'b0;
      end
      // Later assignments override the flag_res clear above.
      if (sel_hlt) begin
        hlt_q <= 1'b1;
      end else if (sel_cmp) begin
        eq_q <= (r0_q == r1_q);
        ov_q <= (r0_q < r1_q);
      end else if (sel_add | sel_add_ov) begin
        out_q <= sum[7:0];
        ov_q  <= sum[8];
      end else if (sel_sub | sel_sub_ov) begin
        out_q <= diff[7:0];
        ov_q  <= diff[8];
      end else if (sel_and) begin
        out_q <= r0_q & r1_q;
      end else if (sel_or) begin
        out_q <= r0_q | r1_q;
      end else if (sel_not) begin
        out_q <= ~r0_q;
      end
    end
  end

  assign r0o        = r0_q;
  assign r1o        = r1_q;
  assign out        = out_q;
  assign flag_ov_o  = ov_q;
  assign flag_eq_o  = eq_q;
  assign flag_hlt_o = hlt_q;

endmodule

// File: tb/tb_goofy_alu.sv
module tb_goofy_alu;

`ifdef GOOFY_ALU_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  // Strobe vector bit positions.
  localparam int ADD = 0, ADDOV = 1, SUB = 2, SUBOV = 3, AND_ = 4,
                 OR_ = 5, NOT_ = 6, CMP = 7, HLT = 8;

  logic       clk = 1'b0;
  logic       res;
  logic       r0w, r1w, flag_res;
  logic [7:0] r0d, r1d;
  logic [8:0] ops;
  logic [7:0] r0o, r1o, out_w;
  logic       ov_w, eq_w, hlt_w;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  goofy_alu dut (
    .clk        (clk),
    .res        (res),
    .r0w        (r0w),
    .r0o        (r0o),
    .r0d        (r0d),
    .r1w        (r1w),
    .r1o        (r1o),
    .r1d        (r1d),
    .flag_ov_o  (ov_w),
    .flag_eq_o  (eq_w),
    .flag_hlt_o (hlt_w),
    .out        (out_w),
    .op_add     (ops[ADD]),
    .op_add_ov  (ops[ADDOV]),
    .op_sub     (ops[SUB]),
    .op_sub_ov  (ops[SUBOV]),
    .op_and     (ops[AND_]),
    .op_or      (ops[OR_]),
    .op_not     (ops[NOT_]),
    .op_cmp     (ops[CMP]),
    .op_hlt     (ops[HLT]),
    .flag_res   (flag_res)
  );

  // Behavioural model: integer arithmetic straight from the operation rules.
  int m_r0, m_r1, m_out, m_ov, m_eq, m_hlt;

  always @(posedge clk) begin
    int a, b, t, ci;
    if (!res) begin
      m_r0 = 0; m_r1 = 0; m_out = 0; m_ov = 0; m_eq = 0; m_hlt = 0;
    end else if (m_hlt == 0) begin
      a = m_r0;
      b = m_r1;
      if (flag_res) begin m_ov = 0; m_eq = 0; end
      if (ops[HLT]) m_hlt = 1;
      else if (ops[CMP]) begin
        m_eq = (a == b) ? 1 : 0;
        m_ov = (a < b) ? 1 : 0;
      end else if (ops[ADD] || ops[ADDOV]) begin
        ci = (!ops[ADD] && CARRY) ? m_ov : 0;
        t = a + b + ci;
        m_out = t % 256;
        m_ov = (t > 255) ? 1 : 0;
      end else if (ops[SUB] || ops[SUBOV]) begin
        ci = (!ops[SUB] && CARRY) ? m_ov : 0;
        t = a - b - ci;
        m_out = (t + 256) % 256;
        m_ov = (t < 0) ? 1 : 0;
      end else if (ops[AND_]) m_out = a & b;
      else if (ops[OR_])  m_out = a | b;
      else if (ops[NOT_]) m_out = 255 - a;
      if (r0w) m_r0 = int'(r0d);
      if (r1w) m_r1 = int'(r1d);
    end
  end

  task automatic cmp1(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model vs DUT on every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp1("r0o", int'(r0o), m_r0);
      cmp1("r1o", int'(r1o), m_r1);
      cmp1("out", int'(out_w), m_out);
      cmp1("ov",  int'(ov_w), m_ov);
      cmp1("eq",  int'(eq_w), m_eq);
      cmp1("hlt", int'(hlt_w), m_hlt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    r0w = 1'b0; r1w = 1'b0; r0d = 8'h00; r1d = 8'h00;
    ops = '0; flag_res = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    r0w = 1'b1; r0d = a; r1w = 1'b1; r1d = b;
    cyc();
    clr();
  endtask

  task automatic do_op(input int bitpos);
    ops = '0;
    ops[bitpos] = 1'b1;
    cyc();
    clr();
  endtask

  initial begin
    // Reset with every other input driven nonzero.
    res = 1'b0; r0w = 1'b1; r1w = 1'b1; r0d = 8'hA5; r1d = 8'h5A;
    ops = '1; flag_res = 1'b1;
    cyc();
    chk_en = 1'b1;
    cmp1("rst_r0", int'(r0o), 0);
    cmp1("rst_r1", int'(r1o), 0);
    cmp1("rst_out", int'(out_w), 0);
    cmp1("rst_ov", int'(ov_w), 0);
    cmp1("rst_eq", int'(eq_w), 0);
    cmp1("rst_hlt", int'(hlt_w), 0);
    clr();
    res = 1'b1;

    // Add with carry out, then chained add_ov.
    load(8'hFF, 8'h02);
    do_op(ADD);
    cmp1("add_out", int'(out_w), 'h01);
    cmp1("add_ov", int'(ov_w), 1);
    load(8'h10, 8'h20);
    do_op(ADDOV);
    cmp1("addov_out", int'(out_w), CARRY ? 'h31 : 'h30);
    cmp1("addov_ov", int'(ov_w), 0);

    // Subtract with and without borrow.
    load(8'h05, 8'h07);
    do_op(SUB);
    cmp1("sub_out", int'(out_w), 'hFE);
    cmp1("sub_ov", int'(ov_w), 1);
    load(8'h07, 8'h05);
    do_op(SUBOV);
    cmp1("subov_out", int'(out_w), CARRY ? 'h01 : 'h02);
    do_op(SUB);
    cmp1("sub2_out", int'(out_w), 'h02);
    cmp1("sub2_ov", int'(ov_w), 0);

    // Logic ops and compare.
    load(8'hF0, 8'h3C);
    do_op(AND_);
    cmp1("and_out", int'(out_w), 'h30);
    do_op(OR_);
    cmp1("or_out", int'(out_w), 'hFC);
    do_op(NOT_);
    cmp1("not_out", int'(out_w), 'h0F);
    do_op(CMP);
    cmp1("cmp_eq", int'(eq_w), 0);
    cmp1("cmp_ov", int'(ov_w), 0);
    cmp1("cmp_out", int'(out_w), 'h0F);
    load(8'hF0, 8'hF0);
    do_op(CMP);
    cmp1("cmp2_eq", int'(eq_w), 1);
    flag_res = 1'b1;
    cyc();
    clr();
    cmp1("fres_eq", int'(eq_w), 0);
    load(8'h01, 8'h02);
    do_op(CMP);
    cmp1("cmp3_ov", int'(ov_w), 1);
    flag_res = 1'b1;
    cyc();
    clr();
    cmp1("fres_ov", int'(ov_w), 0);

    // Priority when several strobes are high.
    load(8'hF0, 8'hF0);
    ops = '0; ops[ADD] = 1'b1; ops[AND_] = 1'b1;
    cyc(); clr();
    cmp1("pri_add_out", int'(out_w), 'hE0);
    cmp1("pri_add_ov", int'(ov_w), 1);
    ops = '0; ops[CMP] = 1'b1; ops[ADD] = 1'b1; flag_res = 1'b1;
    cyc(); clr();
    cmp1("pri_cmp_out", int'(out_w), 'hE0);
    cmp1("pri_cmp_eq", int'(eq_w), 1);
    cmp1("pri_cmp_ov", int'(ov_w), 0);

    // Same-cycle load and op uses the old register value.
    load(8'h01, 8'h01);
    r0w = 1'b1; r0d = 8'h80; ops[ADD] = 1'b1;
    cyc(); clr();
    cmp1("ld_op_out", int'(out_w), 'h02);
    cmp1("ld_op_r0", int'(r0o), 'h80);

    // Halt freezes everything until reset.
    do_op(HLT);
    cmp1("hlt_set", int'(hlt_w), 1);
    r0w = 1'b1; r0d = 8'h55; ops[ADD] = 1'b1; flag_res = 1'b1;
    cyc(); cyc(); clr();
    cmp1("hlt_r0", int'(r0o), 'h80);
    cmp1("hlt_out", int'(out_w), 'h02);
    cmp1("hlt_eq", int'(eq_w), 1);
    cmp1("hlt_hold", int'(hlt_w), 1);
    res = 1'b0;
    cyc();
    res = 1'b1;
    cmp1("rst2_r0", int'(r0o), 0);
    cmp1("rst2_out", int'(out_w), 0);
    cmp1("rst2_eq", int'(eq_w), 0);
    cmp1("rst2_hlt", int'(hlt_w), 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
